// File: rtl/graphics_pkg.sv
// Shared types and constants for the spectrum bar-graph renderer.
//   height_t        : 10-bit bar/peak height in pixels, measured from the bottom
//   rgb332_t        : RGB332 pixel byte
//   render_state_t  : bin-store / peak-update controller states
//   color_mode_t    : colour scheme selector
//   bin_to_height() : bin magnitude top bits -> height saturated to the active area
package graphics_pkg;

    typedef logic [9:0] height_t;
    typedef logic [7:0] rgb332_t;

    localparam rgb332_t BLACK  = 8'h00;
    localparam rgb332_t GREEN  = 8'h1C;
    localparam rgb332_t YELLOW = 8'hFC;
    localparam rgb332_t RED    = 8'hE0;
    localparam rgb332_t WHITE  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWAP,
        ST_PEAK_UPD
    } render_state_t;

    typedef enum logic [1:0] {
        MODE_GREEN    = 2'd0,
        MODE_GRADIENT = 2'd1,
        MODE_WHITE    = 2'd2,
        MODE_RSVD     = 2'd3
    } color_mode_t;

    function automatic height_t bin_to_height(input logic [9:0] top_bits,
                                              input int unsigned v_active);
        return (top_bits > 10'(v_active)) ? 10'(v_active) : top_bits;
    endfunction

endpackage

// File: rtl/bar_graph_renderer_if.sv
// Bin write port of the bar-graph renderer (valid/ready).
//   wr_valid : write request            (master -> slave)
//   wr_index : bar index of the write    (master -> slave)
//   wr_value : bin magnitude             (master -> slave)
//   wr_last  : final write of a bin set  (master -> slave)
//   wr_ready : write accept              (slave -> master)
interface bar_graph_renderer_if #(
    parameter int SAMPLES = 32,
    parameter int WIDTH   = 32
);
    localparam int IDX_W = $clog2(SAMPLES);

    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_index;
    logic [WIDTH-1:0] wr_value;
    logic             wr_last;

    modport master (output wr_valid, output wr_index, output wr_value, output wr_last,
                    input  wr_ready);
    modport slave  (input  wr_valid, input  wr_index, input  wr_value, input  wr_last,
                    output wr_ready);
endinterface

// File: rtl/bar_peak_tracker.sv
// Per-bar peak-hold markers with timed decay.
//   clk, rst_n : clock, asynchronous active-low reset
//   upd_en     : high while the controller is in the peak-update pass
//   upd_idx    : bar currently being updated (walks 0..SAMPLES-1)
//   upd_h      : front-bank height of bar upd_idx
//   upd_last   : the current update cycle handles the final bar
//   rd_idx     : render-pipeline read index
//   rd_peak    : peak height of bar rd_idx
module bar_peak_tracker
    import graphics_pkg::*;
#(
    parameter int SAMPLES   = 32,
    parameter int PEAK_HOLD = 30,
    parameter int DECAY     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       upd_en,
    output logic [$clog2(SAMPLES)-1:0] upd_idx,
    input  height_t                    upd_h,
    output logic                       upd_last,
    input  logic [$clog2(SAMPLES)-1:0] rd_idx,
    output height_t                    rd_peak
);

    localparam int IDX_W  = $clog2(SAMPLES);
    localparam int HOLD_W = (PEAK_HOLD < 1) ? 1 : $clog2(PEAK_HOLD + 1);

    height_t           peak [SAMPLES];
    logic [HOLD_W-1:0] hold [SAMPLES];
    logic [IDX_W-1:0]  idx;

    height_t           peak_nxt;
    logic [HOLD_W-1:0] hold_nxt;

    always_comb begin
        peak_nxt = peak[idx];
        hold_nxt = hold[idx];
        if (upd_h >= peak[idx]) begin
            peak_nxt = upd_h;
            hold_nxt = HOLD_W'(PEAK_HOLD);
        end else if (hold[idx] != '0) begin
            hold_nxt = hold[idx] - 1'b1;
        end else begin
            // clamp at zero rather than wrapping below the baseline
            peak_nxt = (peak[idx] > 10'(DECAY)) ? peak[idx] - 10'(DECAY) : '0;
        end
    end

    // SAMPLES is a power of two, so the iterator wraps to 0 after the last bar
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            for (int unsigned i = 0; i < SAMPLES; i++) begin
                peak[i] <= '0;
                hold[i] <= '0;
            end
        end else if (upd_en) begin
            idx       <= idx + 1'b1;
            peak[idx] <= peak_nxt;
            hold[idx] <= hold_nxt;
        end else begin
            idx <= '0;
        end
    end

    assign upd_idx  = idx;
    assign upd_last = upd_en && (idx == IDX_W'(SAMPLES - 1));
    assign rd_peak  = peak[rd_idx];

endmodule

// File: rtl/bar_graph_renderer.sv
// Pipelined per-pixel spectrum bar-graph renderer.
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   wr          : bin write port (slave), fills the back bank of a double-buffered store
//   frame_start : one-cycle pulse at the start of vertical blanking
//   color_mode  : 0 green, 1 height gradient, 2 white, 3 as 0
//   pix_valid   : pix_x/pix_y address an active pixel
//   pix_x/pix_y : pixel column/row, origin top-left
//   rgb_valid   : pix_valid delayed by 3 cycles
//   rgb         : RGB332 pixel, 0 when rgb_valid is low
module bar_graph_renderer
    import graphics_pkg::*;
#(
    parameter int SAMPLES   = 32,
    parameter int WIDTH     = 32,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BAR_W     = 20,
    parameter int GAP       = 2,
    parameter int PEAK_HOLD = 30,
    parameter int DECAY     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bar_graph_renderer_if.slave        wr,
    input  logic                       frame_start,
    input  logic [1:0]                 color_mode,
    input  logic                       pix_valid,
    input  logic [9:0]                 pix_x,
    input  logic [9:0]                 pix_y,
    output logic                       rgb_valid,
    output logic [7:0]                 rgb
);

    localparam int          IDX_W  = $clog2(SAMPLES);
    localparam int unsigned AREA_W = SAMPLES * BAR_W;
    localparam int unsigned H_LIM  = H_ACTIVE;
    localparam int unsigned V_LIM  = V_ACTIVE;

    // ---------------- bin store and controller ----------------
    render_state_t    state, state_nxt;
    logic             front;
    logic             swap_pending;
    height_t          bank [2][SAMPLES];
    logic             wr_ready_int;
    logic             wr_xfer;
    height_t          wr_h;
    logic             upd_en;
    logic             upd_last;
    logic [IDX_W-1:0] upd_idx;
    height_t          upd_h;
    logic             unused_wr_value;

    assign wr_ready_int    = !swap_pending && (state == ST_IDLE);
    assign wr.wr_ready     = wr_ready_int;
    assign wr_xfer         = wr.wr_valid && wr_ready_int;
    assign wr_h            = bin_to_height(wr.wr_value[WIDTH-1 -: 10], V_ACTIVE);
    assign unused_wr_value = ^wr.wr_value;
    assign upd_en          = (state == ST_PEAK_UPD);
    assign upd_h           = bank[front][upd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A wr_last transfer coinciding with frame_start still swaps this frame.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (frame_start)
                    state_nxt = (swap_pending || (wr_xfer && wr.wr_last)) ? ST_SWAP : ST_PEAK_UPD;
            end
            ST_SWAP:     state_nxt = ST_PEAK_UPD;
            ST_PEAK_UPD: if (upd_last) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Index width covers exactly SAMPLES entries, so every index is in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front        <= 1'b0;
            swap_pending <= 1'b0;
            for (int unsigned i = 0; i < SAMPLES; i++) begin
                bank[0][i] <= '0;
                bank[1][i] <= '0;
            end
        end else begin
            if (state == ST_SWAP) begin
                front        <= ~front;
                swap_pending <= 1'b0;
            end else if (wr_xfer && wr.wr_last) begin
                swap_pending <= 1'b1;
            end
            if (wr_xfer)
                bank[~front][wr.wr_index] <= wr_h;
        end
    end

    // ---------------- render pipeline ----------------
    logic             s1_valid, s1_oob;
    logic [IDX_W-1:0] s1_bar;
    logic [9:0]       s1_col, s1_y;
    color_mode_t      s1_mode;

    logic             s2_valid, s2_oob;
    logic [9:0]       s2_col;
    height_t          s2_h, s2_p, s2_r;
    color_mode_t      s2_mode;

    height_t          rd_peak;
    rgb332_t          pix_color;

    bar_peak_tracker #(
        .SAMPLES  (SAMPLES),
        .PEAK_HOLD(PEAK_HOLD),
        .DECAY    (DECAY)
    ) u_peak (
        .clk     (clk),
        .rst_n   (rst_n),
        .upd_en  (upd_en),
        .upd_idx (upd_idx),
        .upd_h   (upd_h),
        .upd_last(upd_last),
        .rd_idx  (s1_bar),
        .rd_peak (rd_peak)
    );

    // S1: bar/column split. Bars past SAMPLES alias in s1_bar but are flagged out of area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_oob   <= 1'b0;
            s1_bar   <= '0;
            s1_col   <= '0;
            s1_y     <= '0;
            s1_mode  <= MODE_GREEN;
        end else begin
            s1_valid <= pix_valid;
            s1_oob   <= (32'(pix_x) >= AREA_W) || (32'(pix_x) >= H_LIM) || (32'(pix_y) >= V_LIM);
            s1_bar   <= IDX_W'(pix_x / 10'(BAR_W));
            s1_col   <= pix_x % 10'(BAR_W);
            s1_y     <= pix_y;
            s1_mode  <= color_mode_t'(color_mode);
        end
    end

    // S2: height/peak lookup, row converted to height above the bottom line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_oob   <= 1'b0;
            s2_col   <= '0;
            s2_h     <= '0;
            s2_p     <= '0;
            s2_r     <= '0;
            s2_mode  <= MODE_GREEN;
        end else begin
            s2_valid <= s1_valid;
            s2_oob   <= s1_oob;
            s2_col   <= s1_col;
            s2_h     <= bank[front][s1_bar];
            s2_p     <= rd_peak;
            s2_r     <= 10'(V_ACTIVE - 1) - s1_y;
            s2_mode  <= s1_mode;
        end
    end

    // S3: colour select, priority background > peak > bar > background
    always_comb begin
        pix_color = BLACK;
        if (s2_oob || (s2_col >= 10'(BAR_W - GAP))) begin
            pix_color = BLACK;
        end else if ((s2_p != '0) && ((s2_r == s2_p) || (s2_r == s2_p - 10'd1))) begin
            pix_color = (s2_mode == MODE_WHITE) ? RED : WHITE;
        end else if (s2_r < s2_h) begin
            case (s2_mode)
                MODE_GRADIENT: begin
                    if (s2_r < 10'(V_ACTIVE / 3))           pix_color = GREEN;
                    else if (s2_r < 10'((2 * V_ACTIVE) / 3)) pix_color = YELLOW;
                    else                                     pix_color = RED;
                end
                MODE_WHITE: pix_color = WHITE;
                default:    pix_color = GREEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_valid <= 1'b0;
            rgb       <= BLACK;
        end else begin
            rgb_valid <= s2_valid;
            rgb       <= s2_valid ? pix_color : BLACK;
        end
    end

endmodule

// File: tb/tb_bar_graph_renderer.sv
`timescale 1ns/1ps
module tb_bar_graph_renderer;

    localparam int SAMPLES = 32;
    localparam int WIDTH   = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] color_mode = 2'd0;
    logic       pix_valid = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       rgb_valid;
    logic [7:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    bar_graph_renderer_if #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) wr_if ();

    bar_graph_renderer #(
        .SAMPLES(SAMPLES), .WIDTH(WIDTH), .H_ACTIVE(640), .V_ACTIVE(480),
        .BAR_W(20), .GAP(2), .PEAK_HOLD(30), .DECAY(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr_if),
        .frame_start(frame_start),
        .color_mode (color_mode),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .rgb_valid  (rgb_valid),
        .rgb        (rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel in, result sampled three rising edges later
    task automatic render(input string tag, input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] exp);
        @(negedge clk);
        pix_valid = 1'b1; pix_x = x; pix_y = y;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_vld"}, 32'(rgb_valid), 32'd1);
        check(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (wr_if.wr_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic write_bin(input logic [4:0] idx, input logic [31:0] val, input logic last);
        int n = 0;
        @(negedge clk);
        wr_if.wr_valid = 1'b1; wr_if.wr_index = idx; wr_if.wr_value = val; wr_if.wr_last = last;
        while (wr_if.wr_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wr_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
        wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_idle();
    endtask

    initial begin
        wr_if.wr_valid = 1'b0; wr_if.wr_index = '0; wr_if.wr_value = '0; wr_if.wr_last = 1'b0;

        // Reset with pixels flowing
        pix_valid = 1'b1; pix_x = 10'd5; pix_y = 10'd300;
        repeat (4) @(negedge clk);
        check("rst_rgb", 32'(rgb), 32'h00);
        check("rst_rgb_valid", 32'(rgb_valid), 32'd0);
        check("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
        pix_valid = 1'b0; rst_n = 1'b1;

        // First pixel: latency 3, background
        @(negedge clk);
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        check("lat_c1", 32'(rgb_valid), 32'd0);
        @(negedge clk);
        check("lat_c2", 32'(rgb_valid), 32'd0);
        @(negedge clk);
        check("lat_c3", 32'(rgb_valid), 32'd1);
        check("first_px", 32'(rgb), 32'h00);
        @(negedge clk);
        check("lat_c4", 32'(rgb_valid), 32'd0);

        // Bar 0 h=200, then backpressure window
        write_bin(5'd0, 32'h3200_0000, 1'b1);
        check("bp_pending", 32'(wr_if.wr_ready), 32'd0);
        wr_if.wr_valid = 1'b1; wr_if.wr_index = 5'd0; wr_if.wr_value = 32'hFFFF_FFFF; wr_if.wr_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready", 32'(wr_if.wr_ready), 32'd0);
        end
        wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
        render("old_bank", 10'd5, 10'd279, 8'h00);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("swap_ready", 32'(wr_if.wr_ready), 32'd0);
        @(negedge clk);
        check("upd_ready", 32'(wr_if.wr_ready), 32'd0);
        wait_idle();
        check("ready_back", 32'(wr_if.wr_ready), 32'd1);
        render("bar_m0", 10'd5, 10'd282, 8'h1C);
        render("peak_p", 10'd5, 10'd279, 8'hFF);
        render("peak_pm1", 10'd5, 10'd280, 8'hFF);
        render("above_pk", 10'd5, 10'd278, 8'h00);
        render("gap_col", 10'd19, 10'd300, 8'h00);
        render("bp_dropped", 10'd5, 10'd200, 8'h00);

        // Saturation and out-of-area
        write_bin(5'd0, 32'hFFFF_FFFF, 1'b1);
        frame();
        render("sat_bot", 10'd5, 10'd479, 8'h1C);
        render("sat_r478", 10'd5, 10'd1, 8'h1C);
        render("sat_top", 10'd5, 10'd0, 8'hFF);
        render("oob_x640", 10'd640, 10'd100, 8'h00);
        render("gap_x639", 10'd639, 10'd100, 8'h00);

        // wr_last and frame_start together: swap in this frame
        @(negedge clk);
        wr_if.wr_valid = 1'b1; wr_if.wr_index = 5'd3; wr_if.wr_value = 32'h1900_0000;
        wr_if.wr_last = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0; frame_start = 1'b0;
        wait_idle();
        render("b3_peak", 10'd65, 10'd379, 8'hFF);
        render("b3_pm1", 10'd65, 10'd380, 8'hFF);
        render("b3_bar", 10'd65, 10'd381, 8'h1C);

        // Peak hold and decay on bar 3
        write_bin(5'd3, 32'h0, 1'b1);
        frame();
        render("d1_peak", 10'd65, 10'd379, 8'hFF);
        render("d1_nobar", 10'd65, 10'd381, 8'h00);
        for (int k = 2; k <= 30; k++) frame();
        render("d30_peak", 10'd65, 10'd379, 8'hFF);
        render("d30_r96", 10'd65, 10'd383, 8'h00);
        frame();
        render("d31_r96", 10'd65, 10'd383, 8'hFF);
        render("d31_r100", 10'd65, 10'd379, 8'h00);
        frame();
        render("d32_r92", 10'd65, 10'd387, 8'hFF);
        render("d32_r96", 10'd65, 10'd383, 8'h00);
        for (int k = 33; k <= 54; k++) frame();
        render("d54_r4", 10'd65, 10'd475, 8'hFF);
        render("d54_r3", 10'd65, 10'd476, 8'hFF);
        frame();
        render("d55_r3", 10'd65, 10'd476, 8'h00);
        render("d55_r4", 10'd65, 10'd475, 8'h00);
        render("d55_r0", 10'd65, 10'd479, 8'h00);
        frame();
        render("d56_r3", 10'd65, 10'd476, 8'h00);

        // Colour modes on bar 1, h=479
        write_bin(5'd1, 32'h77C0_0000, 1'b1);
        frame();
        color_mode = 2'd1;
        render("m1_r50", 10'd25, 10'd429, 8'h1C);
        render("m1_r160", 10'd25, 10'd319, 8'hFC);
        render("m1_r200", 10'd25, 10'd279, 8'hFC);
        render("m1_r320", 10'd25, 10'd159, 8'hE0);
        render("m1_r400", 10'd25, 10'd79, 8'hE0);
        render("m1_peak", 10'd25, 10'd0, 8'hFF);
        color_mode = 2'd2;
        render("m2_peak", 10'd25, 10'd0, 8'hE0);
        render("m2_bar", 10'd25, 10'd429, 8'hFF);
        color_mode = 2'd3;
        render("m3_bar", 10'd25, 10'd79, 8'h1C);
        color_mode = 2'd0;

        // Reset in the middle of the peak-update pass
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rgb", 32'(rgb), 32'h00);
        check("mid_rst_vld", 32'(rgb_valid), 32'd0);
        check("mid_rst_ready", 32'(wr_if.wr_ready), 32'd1);
        rst_n = 1'b1;
        render("post_rst_px", 10'd25, 10'd429, 8'h00);
        frame();
        render("post_rst_frame", 10'd25, 10'd429, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
